// File: rtl/volt_window_monitor.sv
// Purpose : windowed mean of two ADC mV channels, debounced hysteresis discharge FSM on ch1, overcurrent flag on ch2.
// Latency : sample accepted at edge k appears in avg_* after edge k+1; FSM and overcurrent react one edge later.
// Backpressure: none; one sample per clock while mon_en=1, mon_en=0 flushes the averagers and idles the FSM.
//
// Ports:
//   ad_clk, rst_n            single ADC clock domain, asynchronous active-low reset
//   mon_en                   1 = accept a sample every clock, 0 = flush and idle
//   volt_ch1 / volt_ch2      unsigned mV magnitudes (gap voltage / current-sense voltage)
//   th_hi / th_lo / th_oc    open-gap, discharge and overcurrent thresholds (mV)
//   avg_ch1 / avg_ch2        windowed means; avg_valid once the window is full
//   discharge_active/_start/_end, discharge_len   FSM status, pulses and last length
//   overcurrent              avg_ch2 > th_oc while avg_valid
module volt_window_monitor #(
    parameter int AVG_LOG2 = 3,
    parameter int DEBOUNCE = 4,
    parameter int LEN_W    = 16
) (
    input  logic             ad_clk,
    input  logic             rst_n,
    input  logic             mon_en,
    input  logic [15:0]      volt_ch1,
    input  logic [15:0]      volt_ch2,
    input  logic [15:0]      th_hi,
    input  logic [15:0]      th_lo,
    input  logic [15:0]      th_oc,
    output logic [15:0]      avg_ch1,
    output logic [15:0]      avg_ch2,
    output logic             avg_valid,
    output logic             discharge_active,
    output logic             discharge_start,
    output logic             discharge_end,
    output logic [LEN_W-1:0] discharge_len,
    output logic             overcurrent
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = 16 + AVG_LOG2;
    localparam int DBC_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);
    localparam logic [DBC_W-1:0]  DBC_LAST  = DBC_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPEN,
        ST_PENDING,
        ST_DISCHARGE
    } state_t;

    // ------------------------------------------------------------------
    // Moving average
    // ------------------------------------------------------------------
    logic [15:0]         win_ch1 [DEPTH];
    logic [15:0]         win_ch2 [DEPTH];
    logic [AVG_LOG2-1:0] wr_ptr;
    logic [AVG_LOG2:0]   fill;
    logic [SUM_W-1:0]    sum_ch1;
    logic [SUM_W-1:0]    sum_ch2;
    logic [15:0]         oldest_ch1;
    logic [15:0]         oldest_ch2;
    logic [SUM_W-1:0]    sum_ch1_nxt;
    logic [SUM_W-1:0]    sum_ch2_nxt;

    // Window storage is never cleared: until the window has been filled
    // since the last flush, the entry being overwritten is masked to zero,
    // so stale contents can never leak into the running sum.
    always_comb begin
        oldest_ch1  = (fill == FILL_FULL) ? win_ch1[wr_ptr] : 16'd0;
        oldest_ch2  = (fill == FILL_FULL) ? win_ch2[wr_ptr] : 16'd0;
        sum_ch1_nxt = sum_ch1 + SUM_W'(volt_ch1) - SUM_W'(oldest_ch1);
        sum_ch2_nxt = sum_ch2 + SUM_W'(volt_ch2) - SUM_W'(oldest_ch2);
    end

    always_ff @(posedge ad_clk) begin
        if (mon_en) begin
            win_ch1[wr_ptr] <= volt_ch1;
            win_ch2[wr_ptr] <= volt_ch2;
        end
    end

    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            fill        <= '0;
            sum_ch1     <= '0;
            sum_ch2     <= '0;
            avg_ch1     <= '0;
            avg_ch2     <= '0;
            avg_valid   <= 1'b0;
            overcurrent <= 1'b0;
        end else if (!mon_en) begin
            wr_ptr      <= '0;
            fill        <= '0;
            sum_ch1     <= '0;
            sum_ch2     <= '0;
            avg_ch1     <= '0;
            avg_ch2     <= '0;
            avg_valid   <= 1'b0;
            overcurrent <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + 1'b1;
            sum_ch1 <= sum_ch1_nxt;
            sum_ch2 <= sum_ch2_nxt;
            if (fill != FILL_FULL) begin
                fill <= fill + 1'b1;
            end
            // The mean lags the sum by one edge; a full fill count here
            // means the sum being published contains a complete window.
            avg_ch1     <= sum_ch1[SUM_W-1:AVG_LOG2];
            avg_ch2     <= sum_ch2[SUM_W-1:AVG_LOG2];
            avg_valid   <= (fill == FILL_FULL);
            overcurrent <= avg_valid && (avg_ch2 > th_oc);
        end
    end

    // ------------------------------------------------------------------
    // Discharge FSM on the ch1 mean
    // ------------------------------------------------------------------
    state_t           state;
    logic [DBC_W-1:0] dbc;
    logic [LEN_W-1:0] len_cnt;

    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            dbc              <= '0;
            len_cnt          <= '0;
            discharge_len    <= '0;
            discharge_active <= 1'b0;
            discharge_start  <= 1'b0;
            discharge_end    <= 1'b0;
        end else begin
            discharge_start <= 1'b0;
            discharge_end   <= 1'b0;
            // A flush always wins, even over a DISCHARGE exit on the same
            // edge: no end pulse and the previous length is kept.
            if (!mon_en || !avg_valid) begin
                state            <= ST_IDLE;
                dbc              <= '0;
                len_cnt          <= '0;
                discharge_active <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (avg_ch1 >= th_hi) begin
                            state <= ST_OPEN;
                        end
                    end
                    ST_OPEN: begin
                        if (avg_ch1 < th_lo) begin
                            if (DEBOUNCE == 1) begin
                                state            <= ST_DISCHARGE;
                                dbc              <= '0;
                                len_cnt          <= LEN_W'(1);
                                discharge_active <= 1'b1;
                                discharge_start  <= 1'b1;
                            end else begin
                                state <= ST_PENDING;
                                dbc   <= DBC_W'(1);
                            end
                        end
                    end
                    ST_PENDING: begin
                        if (avg_ch1 < th_lo) begin
                            if (dbc == DBC_LAST) begin
                                state            <= ST_DISCHARGE;
                                dbc              <= '0;
                                len_cnt          <= LEN_W'(1);
                                discharge_active <= 1'b1;
                                discharge_start  <= 1'b1;
                            end else begin
                                dbc <= dbc + 1'b1;
                            end
                        end else begin
                            state <= ST_OPEN;
                            dbc   <= '0;
                        end
                    end
                    ST_DISCHARGE: begin
                        // Only a return above th_hi ends the discharge; the
                        // band between th_lo and th_hi is hysteresis.
                        if (avg_ch1 >= th_hi) begin
                            state            <= ST_OPEN;
                            discharge_len    <= len_cnt;
                            len_cnt          <= '0;
                            discharge_active <= 1'b0;
                            discharge_end    <= 1'b1;
                        end else if (len_cnt != {LEN_W{1'b1}}) begin
                            len_cnt <= len_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_volt_window_monitor.sv
module tb_volt_window_monitor;

    logic        ad_clk = 1'b0;
    logic        rst_n;
    logic        mon_en;
    logic [15:0] volt_ch1, volt_ch2, th_hi, th_lo, th_oc;

    logic [15:0] avg_ch1, avg_ch2;
    logic        avg_valid, discharge_active, discharge_start, discharge_end, overcurrent;
    logic [15:0] discharge_len;

    logic [15:0] s_avg_ch1, s_avg_ch2;
    logic        s_avg_valid, s_discharge_active, s_discharge_start, s_discharge_end, s_overcurrent;
    logic [3:0]  s_discharge_len;

    int errors = 0;
    int checks = 0;

    always #5 ad_clk = ~ad_clk;

    volt_window_monitor dut (
        .ad_clk(ad_clk), .rst_n(rst_n), .mon_en(mon_en),
        .volt_ch1(volt_ch1), .volt_ch2(volt_ch2),
        .th_hi(th_hi), .th_lo(th_lo), .th_oc(th_oc),
        .avg_ch1(avg_ch1), .avg_ch2(avg_ch2), .avg_valid(avg_valid),
        .discharge_active(discharge_active), .discharge_start(discharge_start),
        .discharge_end(discharge_end), .discharge_len(discharge_len),
        .overcurrent(overcurrent)
    );

    volt_window_monitor #(.AVG_LOG2(3), .DEBOUNCE(4), .LEN_W(4)) dut_sat (
        .ad_clk(ad_clk), .rst_n(rst_n), .mon_en(mon_en),
        .volt_ch1(volt_ch1), .volt_ch2(volt_ch2),
        .th_hi(th_hi), .th_lo(th_lo), .th_oc(th_oc),
        .avg_ch1(s_avg_ch1), .avg_ch2(s_avg_ch2), .avg_valid(s_avg_valid),
        .discharge_active(s_discharge_active), .discharge_start(s_discharge_start),
        .discharge_end(s_discharge_end), .discharge_len(s_discharge_len),
        .overcurrent(s_overcurrent)
    );

    typedef struct {
        logic        en;
        logic [15:0] c1;
        logic [15:0] c2;
        logic [15:0] a1;
        logic [15:0] a2;
        logic        v;
        logic        oc;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ad_clk);
        #1;
    endtask

    task automatic feed_chk(input logic [15:0] v, input int n, input logic exp_act);
        for (int i = 0; i < n; i++) begin
            volt_ch1 = v;
            tick();
            chk("feed active", discharge_active, exp_act);
            chk("feed start", discharge_start, 1'b0);
            chk("feed end", discharge_end, 1'b0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " avg_ch1"}, avg_ch1, 0);
        chk({tag, " avg_ch2"}, avg_ch2, 0);
        chk({tag, " avg_valid"}, avg_valid, 0);
        chk({tag, " active"}, discharge_active, 0);
        chk({tag, " start"}, discharge_start, 0);
        chk({tag, " end"}, discharge_end, 0);
        chk({tag, " len"}, discharge_len, 0);
        chk({tag, " overcurrent"}, overcurrent, 0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation still running, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        // Fill ramp from a flush: ch1=1000, ch2=9000, window of 8.
        tbl[0] = '{1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 16'd1000, 16'd9000, 16'd0, 16'd0, 1'b0, 1'b0};
        for (int k = 2; k <= 8; k++)
            tbl[k] = '{1'b1, 16'd1000, 16'd9000, 16'(125 * (k - 1)), 16'(1125 * (k - 1)), 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 16'd1000, 16'd9000, 16'd1000, 16'd9000, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 16'd1000, 16'd9000, 16'd1000, 16'd9000, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 16'd1000, 16'd9000, 16'd1000, 16'd9000, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 16'd1000, 16'd9000, 16'd1000, 16'd9000, 1'b1, 1'b1};

        rst_n = 1'b0; mon_en = 1'b0;
        volt_ch1 = '0; volt_ch2 = '0;
        th_hi = 16'd5000; th_lo = 16'd2000; th_oc = 16'd8000;
        tick(); tick();
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            mon_en = tbl[i].en; volt_ch1 = tbl[i].c1; volt_ch2 = tbl[i].c2;
            tick();
            chk($sformatf("fill[%0d] avg_ch1", i), avg_ch1, tbl[i].a1);
            chk($sformatf("fill[%0d] avg_ch2", i), avg_ch2, tbl[i].a2);
            chk($sformatf("fill[%0d] avg_valid", i), avg_valid, tbl[i].v);
            chk($sformatf("fill[%0d] overcurrent", i), overcurrent, tbl[i].oc);
            chk($sformatf("fill[%0d] active", i), discharge_active, 1'b0);
        end

        // IDLE -> OPEN on a window of 6000.
        feed_chk(16'd6000, 12, 1'b0);

        // Three sub-th_lo means then recovery at exactly th_lo: no discharge.
        feed_chk(16'd0, 8, 1'b0);
        volt_ch1 = 16'd16000; tick();
        chk("debounce3 active", discharge_active, 1'b0);
        volt_ch1 = 16'd6000; tick();
        chk("debounce3 avg at th_lo", avg_ch1, 16'd2000);
        chk("debounce3 start", discharge_start, 1'b0);
        feed_chk(16'd6000, 8, 1'b0);

        // Four sub-th_lo means: discharge starts on the fourth evaluation.
        feed_chk(16'd0, 9, 1'b0);
        volt_ch1 = 16'd3000; tick();
        chk("debounce4 pre active", discharge_active, 1'b0);
        tick();
        chk("debounce4 active", discharge_active, 1'b1);
        chk("debounce4 start", discharge_start, 1'b1);
        chk("debounce4 sat active", s_discharge_active, 1'b1);
        tick();
        chk("start one cycle", discharge_start, 1'b0);
        chk("start hold active", discharge_active, 1'b1);
        // Hysteresis band, then a mean of exactly th_hi ends it.
        feed_chk(16'd3000, 47, 1'b1);
        feed_chk(16'd7000, 5, 1'b1);
        tick();
        chk("exit active", discharge_active, 1'b0);
        chk("exit end pulse", discharge_end, 1'b1);
        chk("exit len", discharge_len, 16'd54);
        chk("exit len saturated", s_discharge_len, 4'd15);
        chk("exit sat end", s_discharge_end, 1'b1);
        tick();
        chk("end one cycle", discharge_end, 1'b0);
        chk("len held", discharge_len, 16'd54);
        feed_chk(16'd7000, 2, 1'b0);

        // Re-enter discharge, then flush on the very edge it would exit.
        feed_chk(16'd0, 9, 1'b0);
        volt_ch1 = 16'd7000; tick();
        chk("reentry pre active", discharge_active, 1'b0);
        tick();
        chk("reentry start", discharge_start, 1'b1);
        feed_chk(16'd7000, 5, 1'b1);
        chk("pre-flush overcurrent", overcurrent, 1'b1);
        mon_en = 1'b0; tick();
        chk("flush active", discharge_active, 1'b0);
        chk("flush no end", discharge_end, 1'b0);
        chk("flush avg_valid", avg_valid, 1'b0);
        chk("flush avg_ch1", avg_ch1, 16'd0);
        chk("flush avg_ch2", avg_ch2, 16'd0);
        chk("flush overcurrent", overcurrent, 1'b0);
        chk("flush len held", discharge_len, 16'd54);
        chk("flush sat len held", s_discharge_len, 4'd15);
        tick();
        chk("flush later end", discharge_end, 1'b0);
        chk("flush later start", discharge_start, 1'b0);

        // Asynchronous reset in the middle of a discharge.
        mon_en = 1'b1;
        feed_chk(16'd6000, 12, 1'b0);
        feed_chk(16'd0, 10, 1'b0);
        tick();
        chk("pre-reset active", discharge_active, 1'b1);
        chk("pre-reset avg_valid", avg_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        chk("async reset sat len", s_discharge_len, 4'd0);
        tick();
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
